// File: rtl/pc_seq_pkg.sv
// Shared definitions for the program-counter sequencer: resolved op encoding
// and the stack-pointer width helper.
package pc_seq_pkg;

    typedef enum logic [2:0] {
        OP_HOLD,
        OP_ADV,
        OP_BRANCH,
        OP_JUMP,
        OP_CALL,
        OP_RET,
        OP_STALL
    } op_e;

    // Bits needed to count 0..depth valid entries
    function automatic int unsigned sp_w(input int unsigned depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/pc_sequencer_return_stack.sv
// Hardware return-address stack; ignores pushes while full and pops while empty.
module return_stack
    import pc_seq_pkg::*;
#(
    parameter int unsigned W     = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      push,
    input  logic                      pop,
    input  logic [W-1:0]              push_data,
    output logic [W-1:0]              top,
    output logic [sp_w(DEPTH)-1:0]    sp,
    output logic                      full,
    output logic                      empty
);

    localparam int unsigned SP_W  = sp_w(DEPTH);
    localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [W-1:0]     mem [DEPTH];
    logic [IDX_W-1:0] wr_idx;
    logic [IDX_W-1:0] rd_idx;
    logic             do_push;
    logic             do_pop;

    assign full    = (sp == SP_W'(DEPTH));
    assign empty   = (sp == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !push && !empty;
    assign wr_idx  = IDX_W'(sp);
    assign rd_idx  = IDX_W'(sp - SP_W'(1));
    assign top     = mem[rd_idx];

    always_ff @(posedge clk) begin
        if (reset) begin
            sp <= '0;
        end else if (do_push) begin
            sp <= sp + SP_W'(1);
        end else if (do_pop) begin
            sp <= sp - SP_W'(1);
        end
    end

    // Entry storage carries no reset; emptiness is tracked by sp alone
    always_ff @(posedge clk) begin
        if (!reset && do_push) begin
            mem[wr_idx] <= push_data;
        end
    end

endmodule

// File: rtl/pc_sequencer.sv
// Program counter with increment, jump, relative branch, call/return and stall.
module pc_sequencer
    import pc_seq_pkg::*;
#(
    parameter int unsigned   W        = 8,
    parameter int unsigned   DEPTH    = 4,
    parameter logic [W-1:0]  RESET_PC = '0
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      stall,
    input  logic                      advance,
    input  logic                      do_jump,
    input  logic                      do_branch,
    input  logic                      do_call,
    input  logic                      do_ret,
    input  logic [W-1:0]              dbus,
    output logic [W-1:0]              pc,
    output logic [sp_w(DEPTH)-1:0]    sp,
    output logic                      overflow,
    output logic                      underflow
);

    op_e          op;
    logic [W-1:0] pc_nxt;
    logic [W-1:0] pc_inc;
    logic [W-1:0] top;
    logic         push;
    logic         pop;
    logic         full;
    logic         empty;

    assign pc_inc = pc + W'(1);

    // Strobe priority: stall > ret > call > jump > branch > advance
    always_comb begin
        op = OP_HOLD;
        if (stall)          op = OP_STALL;
        else if (do_ret)    op = OP_RET;
        else if (do_call)   op = OP_CALL;
        else if (do_jump)   op = OP_JUMP;
        else if (do_branch) op = OP_BRANCH;
        else if (advance)   op = OP_ADV;
    end

    // Branch offset is W bits wide, so W-bit modular add equals sign-extended add
    always_comb begin
        pc_nxt = pc;
        push   = 1'b0;
        pop    = 1'b0;
        case (op)
            OP_ADV:    pc_nxt = pc_inc;
            OP_BRANCH: pc_nxt = pc + dbus;
            OP_JUMP:   pc_nxt = dbus;
            OP_CALL: begin
                pc_nxt = dbus;
                push   = 1'b1;
            end
            OP_RET: begin
                pop = 1'b1;
                if (!empty) pc_nxt = top;
            end
            default:   pc_nxt = pc;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc        <= RESET_PC;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            pc <= pc_nxt;
            if (op == OP_CALL && full)  overflow  <= 1'b1;
            if (op == OP_RET  && empty) underflow <= 1'b1;
        end
    end

    return_stack #(
        .W     (W),
        .DEPTH (DEPTH)
    ) u_stack (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .pop       (pop),
        .push_data (pc_inc),
        .top       (top),
        .sp        (sp),
        .full      (full),
        .empty     (empty)
    );

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer (W=8, DEPTH=4, RESET_PC=0).
module tb_pc_sequencer;

    logic       clk = 1'b0;
    logic       reset;
    logic       stall;
    logic       advance;
    logic       do_jump;
    logic       do_branch;
    logic       do_call;
    logic       do_ret;
    logic [7:0] dbus;
    logic [7:0] pc;
    logic [2:0] sp;
    logic       overflow;
    logic       underflow;

    int checks = 0;
    int errors = 0;

    pc_sequencer #(
        .W        (8),
        .DEPTH    (4),
        .RESET_PC (8'h00)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .stall     (stall),
        .advance   (advance),
        .do_jump   (do_jump),
        .do_branch (do_branch),
        .do_call   (do_call),
        .do_ret    (do_ret),
        .dbus      (dbus),
        .pc        (pc),
        .sp        (sp),
        .overflow  (overflow),
        .underflow (underflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_state(input string tag, input logic [7:0] epc, input logic [2:0] esp,
                               input logic eov, input logic eun);
        check({tag, ".pc"}, 32'(pc), 32'(epc));
        check({tag, ".sp"}, 32'(sp), 32'(esp));
        check({tag, ".ov"}, 32'(overflow), 32'(eov));
        check({tag, ".un"}, 32'(underflow), 32'(eun));
    endtask

    // Apply one cycle of strobes (r s a j b c t = reset stall advance jump branch call ret)
    task automatic step(input logic r, input logic s, input logic a, input logic j,
                        input logic b, input logic c, input logic t, input logic [7:0] d);
        reset = r; stall = s; advance = a; do_jump = j;
        do_branch = b; do_call = c; do_ret = t; dbus = d;
        @(posedge clk);
        #1;
        reset = 0; stall = 0; advance = 0; do_jump = 0;
        do_branch = 0; do_call = 0; do_ret = 0; dbus = 8'h00;
    endtask

    initial begin
        reset = 0; stall = 0; advance = 0; do_jump = 0;
        do_branch = 0; do_call = 0; do_ret = 0; dbus = 8'h00;
        #2;

        step(1, 0, 0, 0, 0, 0, 0, 8'h00);
        check_state("reset", 8'h00, 3'd0, 0, 0);

        // Free-running increment with wrap
        for (int i = 1; i <= 260; i++) begin
            step(0, 0, 1, 0, 0, 0, 0, 8'h00);
            check("adv", 32'(pc), 32'(i % 256));
        end
        check_state("adv_end", 8'h04, 3'd0, 0, 0);

        step(0, 0, 0, 0, 0, 0, 0, 8'h00);
        check("hold", 32'(pc), 32'h04);

        // Relative branches
        step(0, 0, 0, 1, 0, 0, 0, 8'h10);
        check("jump10", 32'(pc), 32'h10);
        step(0, 0, 0, 0, 1, 0, 0, 8'hFD);
        check("br_back", 32'(pc), 32'h0D);
        step(0, 0, 0, 0, 1, 0, 0, 8'h00);
        check("br_self", 32'(pc), 32'h0D);
        step(0, 0, 0, 1, 0, 0, 0, 8'hFE);
        check("jumpFE", 32'(pc), 32'hFE);
        step(0, 0, 0, 0, 1, 0, 0, 8'h05);
        check_state("br_wrap", 8'h03, 3'd0, 0, 0);

        // Nested call / return
        step(0, 0, 0, 1, 0, 0, 0, 8'h05);
        step(0, 0, 0, 0, 0, 1, 0, 8'h40);
        check_state("call1", 8'h40, 3'd1, 0, 0);
        step(0, 0, 0, 0, 0, 1, 0, 8'h80);
        check_state("call2", 8'h80, 3'd2, 0, 0);
        step(0, 0, 0, 0, 0, 0, 1, 8'h00);
        check_state("ret1", 8'h41, 3'd1, 0, 0);
        step(0, 0, 0, 0, 0, 0, 1, 8'h00);
        check_state("ret2", 8'h06, 3'd0, 0, 0);

        // Overflow: five calls from pc=0x06
        step(0, 0, 0, 0, 0, 1, 0, 8'h10);
        step(0, 0, 0, 0, 0, 1, 0, 8'h20);
        step(0, 0, 0, 0, 0, 1, 0, 8'h30);
        step(0, 0, 0, 0, 0, 1, 0, 8'h40);
        check_state("full", 8'h40, 3'd4, 0, 0);
        step(0, 0, 0, 0, 0, 1, 0, 8'h50);
        check_state("ovf", 8'h50, 3'd4, 1, 0);

        // Underflow: unwind four, then one more
        step(0, 0, 0, 0, 0, 0, 1, 8'h00);
        check_state("unw1", 8'h31, 3'd3, 1, 0);
        step(0, 0, 0, 0, 0, 0, 1, 8'h00);
        check_state("unw2", 8'h21, 3'd2, 1, 0);
        step(0, 0, 0, 0, 0, 0, 1, 8'h00);
        check_state("unw3", 8'h11, 3'd1, 1, 0);
        step(0, 0, 0, 0, 0, 0, 1, 8'h00);
        check_state("unw4", 8'h07, 3'd0, 1, 0);
        step(0, 0, 0, 0, 0, 0, 1, 8'h00);
        check_state("udf", 8'h07, 3'd0, 1, 1);

        step(1, 0, 0, 0, 0, 0, 0, 8'h00);
        check_state("reset2", 8'h00, 3'd0, 0, 0);

        // Simultaneous strobes
        step(0, 0, 0, 0, 0, 1, 0, 8'h60);
        check_state("call60", 8'h60, 3'd1, 0, 0);
        step(0, 0, 1, 0, 0, 1, 1, 8'h99);
        check_state("ret_wins", 8'h01, 3'd0, 0, 0);
        step(0, 1, 0, 1, 0, 0, 0, 8'hAA);
        check_state("stall_jump", 8'h01, 3'd0, 0, 0);
        step(0, 0, 1, 1, 1, 0, 0, 8'h33);
        check("jump_wins", 32'(pc), 32'h33);
        step(0, 0, 0, 1, 0, 1, 0, 8'h70);
        check_state("call_wins", 8'h70, 3'd1, 0, 0);
        step(0, 1, 0, 0, 0, 0, 1, 8'h00);
        check_state("stall_ret", 8'h70, 3'd1, 0, 0);
        step(1, 1, 1, 0, 0, 0, 0, 8'h00);
        check_state("reset_stall", 8'h00, 3'd0, 0, 0);

        // Reset mid-sequence with sp=3 and overflow set
        for (int i = 0; i < 5; i++) step(0, 0, 0, 0, 0, 1, 0, 8'h20);
        step(0, 0, 0, 0, 0, 0, 1, 8'h00);
        check_state("pre_rst", 8'h21, 3'd3, 1, 0);
        step(1, 0, 0, 0, 0, 0, 0, 8'h00);
        check_state("mid_rst", 8'h00, 3'd0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 1, 8'h00);
        check_state("rst_ret", 8'h00, 3'd0, 0, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
